// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, bit-period helper, bit-counter width.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

    localparam int BIT_CNT_W = 4;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        RECV   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_rx_state_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        RECV   = 3'd2,
        STOP   = 3'd4
    } uart_rx_state_t;
`endif

    // Truncating period arithmetic, kept identical to the transmitter so a pair agrees.
    function automatic int cycles_per_bit(input int bit_rate, input int clk_hz);
        return (1_000_000_000 / bit_rate) / (1_000_000_000 / clk_hz);
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Generic two-flop synchroniser for asynchronous inputs, with a configurable reset value.
module uart_sync2 #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronised input, mid-bit sampling, one-cycle valid/ferr/break pulses.
// Define UART_RX_PARITY_EN to expect an even-parity bit and drive uart_rx_perr.
module uart_rx
    import uart_pkg::*;
#(
    parameter int BIT_RATE     = 9600,
    parameter int CLK_HZ       = 50_000_000,
    parameter int PAYLOAD_BITS = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    uart_rxd,
    input  logic                    uart_rx_en,
    output logic                    uart_rx_valid,
    output logic [PAYLOAD_BITS-1:0] uart_rx_data,
    output logic                    uart_rx_break,
    output logic                    uart_rx_ferr,
    output logic                    uart_rx_perr
);

    localparam int CYCLES_PER_BIT = cycles_per_bit(BIT_RATE, CLK_HZ);
    localparam int COUNT_REG_LEN  = 1 + $clog2(CYCLES_PER_BIT);

    localparam logic [COUNT_REG_LEN-1:0] HALF_BIT   = COUNT_REG_LEN'(CYCLES_PER_BIT / 2);
    localparam logic [COUNT_REG_LEN-1:0] LAST_CYCLE = COUNT_REG_LEN'(CYCLES_PER_BIT - 1);
    localparam logic [BIT_CNT_W-1:0]     LAST_DATA  = BIT_CNT_W'(PAYLOAD_BITS - 1);
    localparam logic [BIT_CNT_W-1:0]     LAST_STOP  = BIT_CNT_W'(STOP_BITS - 1);

    uart_rx_state_t            state, state_nxt;
    logic [COUNT_REG_LEN-1:0]  cycle_cnt, cycle_cnt_nxt;
    logic [BIT_CNT_W-1:0]      bit_cnt, bit_cnt_nxt;
    logic [PAYLOAD_BITS-1:0]   shift_reg, shift_nxt, data_nxt;
    logic                      stop_err, stop_err_nxt;
    logic                      rxd_s, rxd_prev;
    logic                      sample_pt;
    logic                      valid_nxt, ferr_nxt, brk_nxt;

`ifdef UART_RX_PARITY_EN
    logic                      par_bit, par_bit_nxt, perr_nxt;
`endif

    uart_sync2 #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (uart_rxd),
        .q      (rxd_s)
    );

    assign sample_pt = (cycle_cnt == LAST_CYCLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            cycle_cnt     <= '0;
            bit_cnt       <= '0;
            shift_reg     <= '0;
            stop_err      <= 1'b0;
            rxd_prev      <= 1'b1;
            uart_rx_valid <= 1'b0;
            uart_rx_ferr  <= 1'b0;
            uart_rx_break <= 1'b0;
            uart_rx_data  <= '0;
        end else begin
            state         <= state_nxt;
            cycle_cnt     <= cycle_cnt_nxt;
            bit_cnt       <= bit_cnt_nxt;
            shift_reg     <= shift_nxt;
            stop_err      <= stop_err_nxt;
            rxd_prev      <= rxd_s;
            uart_rx_valid <= valid_nxt;
            uart_rx_ferr  <= ferr_nxt;
            uart_rx_break <= brk_nxt;
            uart_rx_data  <= data_nxt;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            par_bit      <= 1'b0;
            uart_rx_perr <= 1'b0;
        end else begin
            par_bit      <= par_bit_nxt;
            uart_rx_perr <= perr_nxt;
        end
    end
`else
    assign uart_rx_perr = 1'b0;
`endif

    always_comb begin
        state_nxt     = state;
        cycle_cnt_nxt = cycle_cnt + COUNT_REG_LEN'(1);
        bit_cnt_nxt   = bit_cnt;
        shift_nxt     = shift_reg;
        stop_err_nxt  = stop_err;
        valid_nxt     = 1'b0;
        ferr_nxt      = 1'b0;
        brk_nxt       = 1'b0;
        data_nxt      = uart_rx_data;
`ifdef UART_RX_PARITY_EN
        par_bit_nxt   = par_bit;
        perr_nxt      = 1'b0;
`endif

        // Dropping the enable aborts any frame silently.
        if (!uart_rx_en) begin
            state_nxt     = IDLE;
            cycle_cnt_nxt = '0;
            bit_cnt_nxt   = '0;
            stop_err_nxt  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cycle_cnt_nxt = '0;
                    bit_cnt_nxt   = '0;
                    stop_err_nxt  = 1'b0;
                    if (rxd_prev && !rxd_s) begin
                        state_nxt = START;
                    end
                end

                START: begin
                    if (cycle_cnt == HALF_BIT) begin
                        cycle_cnt_nxt = '0;
                        state_nxt     = rxd_s ? IDLE : RECV;
                    end
                end

                RECV: begin
                    if (sample_pt) begin
                        cycle_cnt_nxt = '0;
                        // LSB arrives first, so each sample enters at the MSB and moves right.
                        shift_nxt     = PAYLOAD_BITS'({rxd_s, shift_reg} >> 1);
                        bit_cnt_nxt   = bit_cnt + BIT_CNT_W'(1);
                        if (bit_cnt == LAST_DATA) begin
                            bit_cnt_nxt = '0;
`ifdef UART_RX_PARITY_EN
                            state_nxt   = PARITY;
`else
                            state_nxt   = STOP;
`endif
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (sample_pt) begin
                        cycle_cnt_nxt = '0;
                        par_bit_nxt   = rxd_s;
                        state_nxt     = STOP;
                    end
                end
`endif

                STOP: begin
                    if (sample_pt) begin
                        cycle_cnt_nxt = '0;
                        bit_cnt_nxt   = bit_cnt + BIT_CNT_W'(1);
                        if (!rxd_s) begin
                            stop_err_nxt = 1'b1;
                        end
                        // Leaving at mid stop bit leaves half a bit to catch the next start edge.
                        if (bit_cnt == LAST_STOP) begin
                            state_nxt    = IDLE;
                            bit_cnt_nxt  = '0;
                            stop_err_nxt = 1'b0;
                            if (stop_err || !rxd_s) begin
                                ferr_nxt = 1'b1;
                            end else begin
                                valid_nxt = 1'b1;
                                data_nxt  = shift_reg;
`ifdef UART_RX_PARITY_EN
                                perr_nxt  = ((^shift_reg) != par_bit);
`endif
                            end
                            if ((shift_reg == '0) && !rxd_s) begin
                                brk_nxt = 1'b1;
                            end
                        end
                    end
                end

                default: begin
                    state_nxt     = IDLE;
                    cycle_cnt_nxt = '0;
                    bit_cnt_nxt   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 10 clocks per bit, 8N1 (plus parity when UART_RX_PARITY_EN).
module tb_uart_rx;
    import uart_pkg::*;

    localparam int CLK_HZ   = 1_000_000;
    localparam int BIT_RATE = 100_000;
    localparam int CPB      = 10;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       uart_rxd = 1'b1;
    logic       uart_rx_en = 1'b0;
    logic       uart_rx_valid, uart_rx_break, uart_rx_ferr, uart_rx_perr;
    logic [7:0] uart_rx_data;

    uart_rx #(
        .BIT_RATE     (BIT_RATE),
        .CLK_HZ       (CLK_HZ),
        .PAYLOAD_BITS (8),
        .STOP_BITS    (1)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .uart_rxd      (uart_rxd),
        .uart_rx_en    (uart_rx_en),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_break (uart_rx_break),
        .uart_rx_ferr  (uart_rx_ferr),
        .uart_rx_perr  (uart_rx_perr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic       valid;
        logic       ferr;
        logic       brk;
        logic       perr;
        logic [7:0] data;
    } resp_t;

    resp_t exp_q[$];
    int    vectors = 0;
    int    miscompares = 0;
    int    valid_cyc = -1;
    int    start_cyc = 0;
    logic [7:0] last_data = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_resp(input logic v, input logic f, input logic b, input logic p,
                               input logic [7:0] d);
        resp_t r;
        r = '{valid: v, ferr: f, brk: b, perr: p, data: d};
        exp_q.push_back(r);
    endtask

    task automatic drive_bit(input logic b);
        uart_rxd = b;
        repeat (CPB) @(negedge clk);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_frame_p(input logic [7:0] d, input logic par, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(par);
        drive_bit(stop);
    endtask
`endif

    task automatic send_frame(input logic [7:0] d, input logic stop);
`ifdef UART_RX_PARITY_EN
        send_frame_p(d, ^d, stop);
`else
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
`endif
    endtask

    // Monitor: every status pulse must match the oldest outstanding expectation.
    initial begin
        resp_t act, e;
        forever begin
            @(negedge clk);
            if (resetn && (uart_rx_valid || uart_rx_ferr || uart_rx_break || uart_rx_perr)) begin
                act = '{valid: uart_rx_valid, ferr: uart_rx_ferr, brk: uart_rx_break,
                        perr: uart_rx_perr, data: uart_rx_data};
                if (uart_rx_valid) valid_cyc = cyc;
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_pulse: got v=%0b f=%0b b=%0b p=%0b d=%02h expected no pulse",
                             act.valid, act.ferr, act.brk, act.perr, act.data);
                end else begin
                    e = exp_q.pop_front();
                    vectors++;
                    if (act !== e) begin
                        miscompares++;
                        $display("FAIL rx_resp: got v=%0b f=%0b b=%0b p=%0b d=%02h expected v=%0b f=%0b b=%0b p=%0b d=%02h",
                                 act.valid, act.ferr, act.brk, act.perr, act.data,
                                 e.valid, e.ferr, e.brk, e.perr, e.data);
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish within bound");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(uart_rx_valid), 0);
        check("rst_ferr",  32'(uart_rx_ferr), 0);
        check("rst_break", 32'(uart_rx_break), 0);
        check("rst_perr",  32'(uart_rx_perr), 0);
        check("rst_data",  32'(uart_rx_data), 0);
        resetn = 1'b1;
        uart_rx_en = 1'b1;
        repeat (2 * CPB) @(negedge clk);

        // Single frame, with latency measured from the first edge that sees the start bit.
        expect_resp(1'b1, 1'b0, 1'b0, 1'b0, 8'hA5);
        last_data = 8'hA5;
        start_cyc = cyc + 1;
        send_frame(8'hA5, 1'b1);
`ifdef UART_RX_PARITY_EN
        check("latency", 32'(valid_cyc - start_cyc), 108);
`else
        check("latency", 32'(valid_cyc - start_cyc), 98);
`endif

        // Back-to-back frames with no idle gap.
        expect_resp(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        expect_resp(1'b1, 1'b0, 1'b0, 1'b0, 8'hFF);
        expect_resp(1'b1, 1'b0, 1'b0, 1'b0, 8'h3C);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h3C, 1'b1);
        last_data = 8'h3C;
        drive_bit(1'b1);
        drive_bit(1'b1);

        // Glitch shorter than half a bit.
        uart_rxd = 1'b0;
        repeat (3) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check("idle_after_false_start", 32'(dut.state), 32'(IDLE));

        // Framing error keeps old data, then a long low line is a break.
        expect_resp(1'b0, 1'b1, 1'b0, 1'b0, last_data);
        send_frame(8'h55, 1'b0);
        drive_bit(1'b1);
        expect_resp(1'b0, 1'b1, 1'b1, 1'b0, last_data);
        uart_rxd = 1'b0;
        repeat (20 * CPB) @(negedge clk);
        drive_bit(1'b1);
        drive_bit(1'b1);

        // Receiver disabled for a whole frame, then disabled mid-frame.
        uart_rx_en = 1'b0;
        send_frame(8'h99, 1'b1);
        drive_bit(1'b1);
        uart_rx_en = 1'b1;
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        uart_rx_en = 1'b0;
        for (int i = 0; i < 7; i++) drive_bit(1'b0);
        drive_bit(1'b1);
        uart_rx_en = 1'b1;
        drive_bit(1'b1);
        expect_resp(1'b1, 1'b0, 1'b0, 1'b0, 8'hC3);
        send_frame(8'hC3, 1'b1);
        last_data = 8'hC3;
        drive_bit(1'b1);

        // Reset in the middle of 0x81 payload.
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b0);
        resetn = 1'b0;
        uart_rxd = 1'b1;
        repeat (2) @(negedge clk);
        check("inrst_valid", 32'(uart_rx_valid), 0);
        check("inrst_ferr",  32'(uart_rx_ferr), 0);
        check("inrst_break", 32'(uart_rx_break), 0);
        check("inrst_perr",  32'(uart_rx_perr), 0);
        check("inrst_data",  32'(uart_rx_data), 0);
        resetn = 1'b1;
        last_data = 8'h00;
        repeat (2 * CPB) @(negedge clk);
        expect_resp(1'b1, 1'b0, 1'b0, 1'b0, 8'h42);
        send_frame(8'h42, 1'b1);
        drive_bit(1'b1);

`ifdef UART_RX_PARITY_EN
        // 0x07 has odd weight: parity bit 0 is wrong, 1 is right.
        expect_resp(1'b1, 1'b0, 1'b0, 1'b1, 8'h07);
        send_frame_p(8'h07, 1'b0, 1'b1);
        expect_resp(1'b1, 1'b0, 1'b0, 1'b0, 8'h07);
        send_frame_p(8'h07, 1'b1, 1'b1);
        drive_bit(1'b1);
`endif

        repeat (2 * CPB) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
